// File: rtl/alu_arbiter.sv
// alu_arbiter
//
// Shares one combinational N-bit ALU between two requesters. One operation
// is in flight at a time: IDLE accepts a request (round-robin between the two
// requesters), EXEC presents the captured operands to the ALU for exactly one
// cycle and registers the result, RESP holds the tagged result until the
// consumer takes it.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   reqX_valid / reqX_ready  request handshake for requester X (ready is
//                            combinational, high only for the granted requester
//                            while IDLE)
//   reqX_inp1/inp2/func      operands and function code of requester X
//   resp_valid / resp_ready  response handshake
//   resp_id                  requester that issued the response
//   resp_out / resp_zero     registered result and zero flag
//   alu_inp1/inp2/func       registered operands toward the ALU (zero/MOV when
//                            no operation is being executed)
//   alu_out / alu_zero       combinational result from the ALU
module alu_arbiter #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_inp1,
  input  logic [N-1:0] req0_inp2,
  input  logic [2:0]   req0_func,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_inp1,
  input  logic [N-1:0] req1_inp2,
  input  logic [2:0]   req1_func,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [N-1:0] resp_out,
  output logic         resp_zero,
  output logic [N-1:0] alu_inp1,
  output logic [N-1:0] alu_inp2,
  output logic [2:0]   alu_func,
  input  logic [N-1:0] alu_out,
  input  logic         alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state_r;
  state_t       state_s;
  logic         prio_r;
  logic         id_r;
  logic [2:0]   func_r;
  logic [N-1:0] alu_inp1_r;
  logic [N-1:0] alu_inp2_r;
  logic [2:0]   alu_func_r;
  logic [N-1:0] result_r;
  logic         zero_r;
  logic         resp_valid_r;

  logic         grant_s;
  logic         accept_s;
  logic [N-1:0] sel_inp1_s;
  logic [N-1:0] sel_inp2_s;
  logic [2:0]   sel_func_s;
  logic         sel_is_alu_s;
  logic         is_alu_s;

  // Grant selection: a lone valid requester wins, otherwise the priority pointer decides
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = prio_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign accept_s   = (state_r == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept_s && (grant_s == 1'b0);
  assign req1_ready = accept_s && (grant_s == 1'b1);

  // Operand mux for the granted requester
  always_comb begin
    sel_inp1_s = req0_inp1;
    sel_inp2_s = req0_inp2;
    sel_func_s = req0_func;
    if (grant_s) begin
      sel_inp1_s = req1_inp1;
      sel_inp2_s = req1_inp2;
      sel_func_s = req1_func;
    end else begin
      sel_inp1_s = req0_inp1;
      sel_inp2_s = req0_inp2;
      sel_func_s = req0_func;
    end
  end

  // Codes 110 and 111 are NOPs and never reach the ALU
  assign sel_is_alu_s = (sel_func_s < 3'd6);
  assign is_alu_s     = (func_r < 3'd6);

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        state_s = RESP;
      end
      RESP: begin
        if (resp_valid_r && resp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request capture and round-robin pointer update on the accepting edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_r <= 1'b0;
      id_r   <= 1'b0;
      func_r <= 3'd0;
    end else if (accept_s) begin
      prio_r <= ~grant_s;
      id_r   <= grant_s;
      func_r <= sel_func_s;
    end else begin
      prio_r <= prio_r;
      id_r   <= id_r;
      func_r <= func_r;
    end
  end

  // ALU drive registers: loaded on accept for real ALU ops, cleared once EXEC ends,
  // so the ALU only ever sees non-zero inputs during an EXEC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_inp1_r <= '0;
      alu_inp2_r <= '0;
      alu_func_r <= 3'd0;
    end else if (accept_s && sel_is_alu_s) begin
      alu_inp1_r <= sel_inp1_s;
      alu_inp2_r <= sel_inp2_s;
      alu_func_r <= sel_func_s;
    end else if (accept_s || (state_r == EXEC)) begin
      alu_inp1_r <= '0;
      alu_inp2_r <= '0;
      alu_func_r <= 3'd0;
    end else begin
      alu_inp1_r <= alu_inp1_r;
      alu_inp2_r <= alu_inp2_r;
      alu_func_r <= alu_func_r;
    end
  end

  // Result capture at the end of EXEC; a NOP keeps the old result and recomputes its zero flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_r <= '0;
      zero_r   <= 1'b0;
    end else if ((state_r == EXEC) && is_alu_s) begin
      result_r <= alu_out;
      zero_r   <= alu_zero;
    end else if (state_r == EXEC) begin
      result_r <= result_r;
      zero_r   <= (result_r == '0);
    end else begin
      result_r <= result_r;
      zero_r   <= zero_r;
    end
  end

  // Response valid flag: raised leaving EXEC, dropped on the response handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_r <= 1'b0;
    end else if (state_r == EXEC) begin
      resp_valid_r <= 1'b1;
    end else if (resp_valid_r && resp_ready) begin
      resp_valid_r <= 1'b0;
    end else begin
      resp_valid_r <= resp_valid_r;
    end
  end

  assign resp_valid = resp_valid_r;
  assign resp_id    = id_r;
  assign resp_out   = result_r;
  assign resp_zero  = zero_r;
  assign alu_inp1   = alu_inp1_r;
  assign alu_inp2   = alu_inp2_r;
  assign alu_func   = alu_func_r;

endmodule
